ofm_accum_quant: RTL

//  Output-pixel post-processor directly upstream of the OFM buffer. Accumulates
//  cfg_num_ch signed partial sums from the PE array per output pixel. Adds bias,

---
 rtl/ofm_accum_quant.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ofm_accum_quant.sv
// Output-pixel post-processor: accumulates signed psums, adds bias, rounds/shifts and saturates.
// Build option: define OFM_ACC_RELU_EN for an unsigned ReLU output; default is signed clamp.
module ofm_accum_quant #(
    parameter int PSUM_WIDTH   = 24,
    parameter int ACC_WIDTH    = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cfg_num_ch,
    input  logic [CNT_WIDTH-1:0]    cfg_num_pix,
    input  logic [4:0]              cfg_shift,
    input  logic [ACC_WIDTH-1:0]    cfg_bias,
    input  logic                    psum_valid,
    input  logic [PSUM_WIDTH-1:0]   psum_data,
    output logic                    psum_ready,
    output logic                    ofm_valid,
    output logic [OUTPUT_WIDTH-1:0] ofm_data,
    input  logic                    ofm_ready,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds data stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, OUT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    bias_q;
    logic [CNT_WIDTH-1:0]    ch_cnt_q;
    logic [CNT_WIDTH-1:0]    pix_cnt_q;
    logic [CNT_WIDTH-1:0]    last_ch_q;
    logic [CNT_WIDTH-1:0]    last_pix_q;
    logic [4:0]              shift_q;
    logic                    psum_ready_q;
    logic                    ofm_valid_q;
    logic                    done_q;
    logic [OUTPUT_WIDTH-1:0] ofm_data_q;

    logic [ACC_WIDTH:0]        sum_w;
    logic [ACC_WIDTH-1:0]      acc_d;
    logic [ACC_WIDTH:0]        half_w;
    logic signed [ACC_WIDTH:0] rnd_w;
    logic signed [ACC_WIDTH:0] r_w;
    logic [OUTPUT_WIDTH-1:0]   quant_d;

    // One guard bit on the add: a sign disagreement between the top two bits means overflow.
    assign sum_w = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-PSUM_WIDTH){psum_data[PSUM_WIDTH-1]}}, psum_data};

    always_comb begin
        acc_d = sum_w[ACC_WIDTH-1:0];
        if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
            acc_d = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    // The rounding add is done one bit wider than the accumulator, so it cannot overflow.
    always_comb begin
        half_w = '0;
        if (shift_q != 5'd0) half_w[shift_q - 5'd1] = 1'b1;
        rnd_w = {acc_q[ACC_WIDTH-1], acc_q} + half_w;
        r_w   = rnd_w >>> shift_q;
    end

    always_comb begin
        quant_d = r_w[OUTPUT_WIDTH-1:0];
`ifdef OFM_ACC_RELU_EN
        if (r_w[ACC_WIDTH])
            quant_d = '0;
        else if (|r_w[ACC_WIDTH-1:OUTPUT_WIDTH])
            quant_d = '1;
`else
        if (!(&r_w[ACC_WIDTH:OUTPUT_WIDTH-1]) && (|r_w[ACC_WIDTH:OUTPUT_WIDTH-1])) begin
            quant_d = r_w[ACC_WIDTH] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            bias_q       <= '0;
            ch_cnt_q     <= '0;
            pix_cnt_q    <= '0;
            last_ch_q    <= '0;
            last_pix_q   <= '0;
            shift_q      <= '0;
            psum_ready_q <= 1'b0;
            ofm_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            ofm_data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Counts of zero are treated as one; store the terminal index directly.
                        last_ch_q    <= (cfg_num_ch  == '0) ? '0 : cfg_num_ch  - CNT_ONE;
                        last_pix_q   <= (cfg_num_pix == '0) ? '0 : cfg_num_pix - CNT_ONE;
                        shift_q      <= cfg_shift;
                        bias_q       <= cfg_bias;
                        acc_q        <= cfg_bias;
                        ch_cnt_q     <= '0;
                        pix_cnt_q    <= '0;
                        psum_ready_q <= 1'b1;
                        state_q      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (psum_valid && psum_ready_q) begin
                        acc_q    <= acc_d;
                        ch_cnt_q <= ch_cnt_q + CNT_ONE;
                        if (ch_cnt_q == last_ch_q) begin
                            psum_ready_q <= 1'b0;
                            state_q      <= QUANT;
                        end
                    end
                end
                QUANT: begin
                    ofm_data_q  <= quant_d;
                    ofm_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (ofm_ready) begin
                        ofm_valid_q <= 1'b0;
                        if (pix_cnt_q == last_pix_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            pix_cnt_q    <= pix_cnt_q + CNT_ONE;
                            acc_q        <= bias_q;
                            ch_cnt_q     <= '0;
                            psum_ready_q <= 1'b1;
                            state_q      <= ACCUM;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psum_ready  = psum_ready_q;
    assign ofm_valid   = ofm_valid_q;
    assign ofm_data    = ofm_data_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
